// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave backed by a word-addressed SRAM with independent read and write paths.
// Define AXI_SRAM_DELAY_EN to stretch the WAIT states to DELAY cycles.
module axi_lite_sram #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned DELAY     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DELAY + 2);
`ifdef AXI_SRAM_DELAY_EN
  localparam int unsigned DLY = (DELAY == 0) ? 1 : DELAY;
`else
  // Loading the wait counter with 1 makes each WAIT state last exactly one cycle.
  localparam int unsigned DLY = 1;
`endif
  localparam logic [32:0] LIMIT  = 33'(BASE_ADDR) + 33'(DEPTH) * 33'd4;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  r_state_t         r_state;
  logic [31:0]      r_addr;
  logic [CNT_W-1:0] r_cnt;

  w_state_t         w_state;
  logic [31:0]      w_addr;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic [CNT_W-1:0] w_cnt;

  logic             r_hit_c;
  logic [IDX_W-1:0] r_idx_c;
  logic             w_hit_c;
  logic [IDX_W-1:0] w_idx_c;
  logic             w_commit_c;
  logic             aw_take_c;
  logic             w_take_c;

  function automatic logic in_range(input logic [31:0] a);
    return (33'(a) >= 33'(BASE_ADDR)) && (33'(a) < LIMIT);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  always_comb begin
    r_hit_c    = in_range(r_addr);
    r_idx_c    = word_idx(r_addr);
    w_hit_c    = in_range(w_addr);
    w_idx_c    = word_idx(w_addr);
    w_commit_c = (w_state == W_WAIT) && (w_cnt <= CNT_W'(1));
    aw_take_c  = awvalid && awready;
    w_take_c   = wvalid && wready;
  end

  // Read path: the SRAM word is sampled on the WAIT->RESP edge, before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
      rresp   <= OKAY;
      r_addr  <= 32'h0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_addr  <= araddr;
            arready <= 1'b0;
            r_cnt   <= CNT_W'(DLY);
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt <= CNT_W'(1)) begin
            rvalid  <= 1'b1;
            rdata   <= r_hit_c ? mem[r_idx_c] : 32'h0;
            rresp   <= r_hit_c ? OKAY : SLVERR;
            r_state <= R_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write path: AW and W are collected independently; a cleared ready marks that half as held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      w_addr  <= 32'h0;
      w_data  <= 32'h0;
      w_strb  <= 4'h0;
      w_cnt   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_take_c) begin
            w_addr  <= awaddr;
            awready <= 1'b0;
          end
          if (w_take_c) begin
            w_data <= wdata;
            w_strb <= wstrb;
            wready <= 1'b0;
          end
          if ((aw_take_c || !awready) && (w_take_c || !wready)) begin
            w_cnt   <= CNT_W'(DLY);
            w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_commit_c) begin
            bvalid  <= 1'b1;
            bresp   <= w_hit_c ? OKAY : SLVERR;
            w_state <= W_RESP;
          end else begin
            w_cnt <= w_cnt - CNT_W'(1);
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage is never reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit_c && w_hit_c) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[w_idx_c][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

endmodule
